binary_to_bcd_seq: RTL
======================

BINARY_TO_BCD_SEQ -- requirements
Module: binary_to_bcd_seq

Interface
REQ-001 Parameter BIN_W, default 13, SHALL set the binary input width; legal range 4..32.
REQ-002 Parameter BCD_DIGITS, default 4, SHALL set the number of 4-bit BCD output digits; 10^BCD_DIGITS > 2^BIN_W-1 is required (elaboration error otherwise).
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  binary_in is valid this cycle.
REQ-006 in_ready  output  1  block can accept a new value.
REQ-007 binary_in  input  BIN_W  unsigned binary value to convert.
REQ-008 out_valid  output  1  BCD_out holds a completed result.
REQ-009 out_ready  input  1  consumer accepts BCD_out this cycle.
REQ-010 BCD_out  output  4*BCD_DIGITS  packed BCD result; digit 0 (units) in bits [3:0].
REQ-011 busy  output  1  high while a conversion is in progress (SHIFT state).

Function
REQ-012 FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-013 IDLE: in_ready=1, out_valid=0; on in_valid=1 the block SHALL capture binary_in, clear the BCD scratch, load the shift counter with BIN_W, go to SHIFT.
REQ-014 SHIFT: each cycle, every BCD digit >4 SHALL get +3 (all digits tested on pre-correction values, no inter-digit carry), then the {BCD, binary} scratch SHALL shift left by one; counter decrements.
REQ-015 SHIFT SHALL exit to DONE on the edge performing the BIN_W-th shift; BCD_out is loaded from the scratch on that same edge.
REQ-016 Latency: out_valid SHALL rise exactly BIN_W cycles after the accepting edge (13 for defaults), independent of data value.
REQ-017 DONE: out_valid=1, BCD_out stable; on out_ready=1 go to IDLE; without out_ready hold indefinitely.
REQ-018 in_ready SHALL be 0 in SHIFT and DONE; in_valid there is ignored and binary_in is not sampled.
REQ-019 Max throughput: one result per BIN_W+2 cycles (accept, BIN_W shifts, handoff).
REQ-020 BCD_out SHALL retain the last result after the DONE->IDLE handoff until the next completion overwrites it.
REQ-021 Every output digit SHALL be in 0..9; no overflow is possible under REQ-002.

Reset
REQ-022 rst_n=0 SHALL asynchronously force IDLE, in_ready=1 (after deassertion), out_valid=0, busy=0, BCD_out=0, counter and scratch =0.
REQ-023 Reset asserted mid-SHIFT or in DONE SHALL discard the conversion; no out_valid pulse follows reset deassertion.
REQ-024 First acceptance is permitted on the first rising edge with rst_n=1.

Structure
REQ-025 Shared package bcd_pkg SHALL hold the FSM state enum and a function computing the minimum digit count for a binary width (used by the REQ-002 check).
REQ-026 One sub-module bcd_dabble_digit (4-bit in, 4-bit out, +3 when >4, purely combinational) SHALL be instantiated BCD_DIGITS times via generate.
REQ-027 Counter width SHALL be $clog2(BIN_W+1); scratch width BIN_W+4*BCD_DIGITS.

Verification
REQ-028 Defaults, binary_in=0 accepted -> after 13 cycles out_valid=1, BCD_out=16'h0000.
REQ-029 Defaults, binary_in=8191 -> BCD_out=16'h8191 with out_valid exactly 13 cycles after accept; binary_in=4095 -> 16'h4095.
REQ-030 out_ready held 0 for 20 cycles after completion -> out_valid and BCD_out stable, in_ready=0 throughout; new in_valid ignored.
REQ-031 rst_n pulsed low during cycle 6 of SHIFT -> out_valid never asserts, next accepted value 1234 yields 16'h1234.
REQ-032 BIN_W=20, BCD_DIGITS=7: 1048575 -> 28'h1048575 after 20 cycles; back-to-back stream of 100 random values with random out_ready matches a reference model, one result per accepted input, in order.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Decimal digits needed to represent the largest value of an unsigned bin_w-bit number.
  function automatic int min_bcd_digits(input int bin_w);
    logic [63:0] v;
    int          n;
    v = (64'd1 << bin_w) - 64'd1;
    n = 1;
    for (int i = 0; i < 20; i++) begin
      if (v > 64'd9) begin
        v = v / 64'd10;
        n = n + 1;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/bcd_dabble_digit.sv
// Double-dabble correction for one BCD digit: adds 3 when the digit exceeds 4.
// Purely combinational, zero latency, no flow control.
module bcd_dabble_digit (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  assign digit_o = (digit_i > 4'd4) ? (digit_i + 4'd3) : digit_i;

endmodule

// File: rtl/binary_to_bcd_seq.sv
// Sequential double-dabble converter: one bit per cycle, result valid BIN_W cycles after accept.
// Accepts only in IDLE; a finished result is held in DONE until out_ready.
module binary_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W      = 13,
  parameter int BCD_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [BIN_W-1:0]        binary_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [4*BCD_DIGITS-1:0] BCD_out,
  output logic                    busy
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int BCD_W = 4 * BCD_DIGITS;
  localparam int SCR_W = BIN_W + BCD_W;

  if (BIN_W < 4 || BIN_W > 32) begin : g_bin_w_chk
    $error("binary_to_bcd_seq: BIN_W must be in 4..32");
  end
  if (BCD_DIGITS < min_bcd_digits(BIN_W)) begin : g_digits_chk
    $error("binary_to_bcd_seq: BCD_DIGITS too small for BIN_W");
  end

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SCR_W-1:0]   scr_q, scr_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [BCD_W-1:0]   bcd_adj;
  logic [SCR_W-1:0]   scr_shift;

  // Every digit is corrected from its pre-correction value; no carry between digits.
  for (genvar d = 0; d < BCD_DIGITS; d++) begin : g_digit
    bcd_dabble_digit u_digit (
      .digit_i (scr_q[BIN_W+4*d +: 4]),
      .digit_o (bcd_adj[4*d +: 4])
    );
  end

  assign scr_shift = {bcd_adj, scr_q[BIN_W-1:0]} << 1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    scr_d   = scr_q;
    bcd_d   = bcd_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          scr_d   = {{BCD_W{1'b0}}, binary_in};
          cnt_d   = CNT_W'(BIN_W);
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        scr_d = scr_shift;
        cnt_d = cnt_q - CNT_W'(1);
        // Final shift: publish the BCD field on the same edge.
        if (cnt_q == CNT_W'(1)) begin
          bcd_d   = scr_shift[SCR_W-1 -: BCD_W];
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      scr_q   <= '0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      scr_q   <= scr_d;
      bcd_q   <= bcd_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_SHIFT);
  assign BCD_out   = bcd_q;

endmodule
